// File: rtl/mem_io_pkg.sv
// Shared constants and address decode for the CPU byte-bus responder.
package mem_io_pkg;

  localparam logic [15:0] IO_PAGE      = 16'h0003;
  localparam logic [31:0] IO_DATA_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_CTRL_ADDR = 32'h0003_0004;

  typedef enum logic [1:0] {
    ACC_RAM,
    ACC_IO_DATA,
    ACC_IO_CTRL,
    ACC_IO_OTHER
  } acc_kind_e;

  function automatic acc_kind_e decode_addr(input logic [31:0] a);
    if (a[31:16] != IO_PAGE) return ACC_RAM;
    if (a == IO_DATA_ADDR)   return ACC_IO_DATA;
    if (a == IO_CTRL_ADDR)   return ACC_IO_CTRL;
    return ACC_IO_OTHER;
  endfunction

  function automatic logic [7:0] io_status(input logic tx_full, input logic rx_empty);
    return {6'b0, !tx_full, !rx_empty};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, 2^AW entries, wrap-bit pointers; head is the oldest entry.
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [2**AW];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mem_io_responder.sv
// Byte-bus target: RAM, RX/TX FIFO I/O page and sticky halt; stalls the core via rdy_out.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt_out
);

  acc_kind_e          kind;
  logic               accept;
  logic [RAM_AW-1:0]  ram_idx;
  logic               rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]         rx_head;
  logic               rx_pop, tx_push;
  logic [7:0]         ram [2**RAM_AW];

  assign kind    = decode_addr(mem_a);
  assign ram_idx = mem_a[RAM_AW-1:0];

  // Depends only on bus inputs and registered flags, so no loop through the core.
  assign rdy_out = !halt_out
                 && !((kind == ACC_IO_DATA) && !mem_wr && rx_empty)
                 && !((kind == ACC_IO_DATA) &&  mem_wr && tx_full);
  assign accept  = rdy_out;

  assign rx_pop  = accept && (kind == ACC_IO_DATA) && !mem_wr;
  assign tx_push = accept && (kind == ACC_IO_DATA) &&  mem_wr;

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;

  byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (rx_valid && !rx_full),
    .push_data (rx_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (tx_push),
    .push_data (mem_dout),
    .pop       (tx_ready && !tx_empty),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_data)
  );

  always_ff @(posedge clk_in) begin
    if (accept && mem_wr && (kind == ACC_RAM)) ram[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_din <= '0;
    end else if (accept && !mem_wr) begin
      unique case (kind)
        ACC_RAM:     mem_din <= ram[ram_idx];
        ACC_IO_DATA: mem_din <= rx_head;
        ACC_IO_CTRL: mem_din <= io_status(tx_full, rx_empty);
        default:     mem_din <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      halt_out <= 1'b0;
    end else if (accept && mem_wr && (kind == ACC_IO_CTRL)) begin
      halt_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: queue-based reference model, randomized traffic.
module tb_mem_io_responder;

  localparam logic [31:0] A_DATA = 32'h0003_0000;
  localparam logic [31:0] A_CTRL = 32'h0003_0004;
  localparam logic [31:0] A_IDLE = 32'h0003_0008;
  localparam int          DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt_out;

  always #5 clk = ~clk;

  mem_io_responder #(.RAM_AW(17), .FIFO_AW(4)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .rdy_out  (rdy_out),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .halt_out (halt_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RAM as associative array, FIFOs as queues.
  logic [7:0]  ram_m [int];
  logic [7:0]  rxq [$];
  logic [7:0]  txq [$];
  int          exp_q [$];
  bit          halt_m = 1'b0;
  bit          m_rdy  = 1'b0;
  bit          st_rxpush, st_txpop, st_wr;
  logic [31:0] st_a;
  logic [7:0]  st_d, st_rx;
  int          st_rdval;
  bit          is_data;
  int          mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      rxq.delete();
      txq.delete();
      halt_m = 1'b0;
      check("reset_mem_din", int'(mem_din), 0);
    end
    is_data = (mem_a == A_DATA);
    m_rdy = !halt_m && !(is_data && !mem_wr && rxq.size() == 0)
                    && !(is_data &&  mem_wr && txq.size() == DEPTH);
    check("rdy_out",  int'(rdy_out),  int'(m_rdy));
    check("rx_ready", int'(rx_ready), int'(rxq.size() < DEPTH));
    check("tx_valid", int'(tx_valid), int'(txq.size() > 0));
    check("halt_out", int'(halt_out), int'(halt_m));
    if (txq.size() > 0) check("tx_data", int'(tx_data), int'(txq[0]));
    st_a  = mem_a;
    st_wr = mem_wr;
    st_d  = mem_dout;
    st_rx = rx_data;
    st_rdval = -1;
    if (mem_a[31:16] != 16'h0003)
      st_rdval = ram_m.exists(int'(mem_a[16:0])) ? int'(ram_m[int'(mem_a[16:0])]) : -1;
    else if (is_data)
      st_rdval = (rxq.size() > 0) ? int'(rxq[0]) : -1;
    else if (mem_a == A_CTRL)
      st_rdval = ((txq.size() < DEPTH) ? 2 : 0) + ((rxq.size() > 0) ? 1 : 0);
    else
      st_rdval = 0;
    st_rxpush = (rx_valid === 1'b1) && (rxq.size() < DEPTH);
    st_txpop  = (tx_ready === 1'b1) && (txq.size() > 0);
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_rdy) begin
        if (st_wr) begin
          if (st_a == A_DATA)                txq.push_back(st_d);
          else if (st_a == A_CTRL)           halt_m = 1'b1;
          else if (st_a[31:16] != 16'h0003)  ram_m[int'(st_a[16:0])] = st_d;
        end else begin
          exp_q.push_back(st_rdval);
          if (st_a == A_DATA) void'(rxq.pop_front());
        end
      end
      if (st_txpop)  void'(txq.pop_front());
      if (st_rxpush) rxq.push_back(st_rx);
    end
  end

  // Monitor: each accepted read returns data by the following falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e >= 0) check("read_data", int'(mem_din), mon_e);
    end
  end

  // Serial-side drivers: random when enabled, otherwise follow manual controls.
  bit         feed_en = 1'b0, drain_rand = 1'b0;
  logic       man_rx_valid = 1'b0, man_tx_ready = 1'b1;
  logic [7:0] man_rx_data = 8'h00;

  always @(posedge clk) begin
    #2;
    if (feed_en) begin
      rx_valid = (($urandom % 3) == 0);
      rx_data  = 8'($urandom);
    end else begin
      rx_valid = man_rx_valid;
      rx_data  = man_rx_data;
    end
    tx_ready = drain_rand ? 1'($urandom % 2) : man_tx_ready;
  end

  task automatic idle();
    mem_a    = A_IDLE;
    mem_wr   = 1'b1;
    mem_dout = 8'h00;
  endtask

  task automatic access(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (m_rdy) begin
        @(posedge clk);
        #1;
        idle();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL access_timeout addr=0x%08h actual=stalled required=accepted", a);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push_rx(input logic [7:0] d);
    man_rx_data  = d;
    man_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    man_rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] ram_addr(input int i);
    logic [16:0] idx;
    logic [14:0] hi;
    idx = 17'(i * 17'h2345 + 5);
    hi  = 15'(($urandom % 4) * 2);
    return {hi, idx};
  endfunction

  int pick;

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    access(32'h0000_0010, 1'b1, 8'hA5);
    access(32'h0000_0010, 1'b0, 8'h00);
    access(32'h0002_0000, 1'b1, 8'h77);
    access(32'h0000_0000, 1'b0, 8'h00);

    fork
      access(A_DATA, 1'b0, 8'h00);
      begin
        repeat (6) @(posedge clk);
        #1;
        push_rx(8'h41);
      end
    join
    access(A_CTRL, 1'b0, 8'h00);

    push_rx(8'h11);
    push_rx(8'h22);
    fork
      access(A_DATA, 1'b0, 8'h00);
      push_rx(8'h33);
    join
    access(A_CTRL, 1'b0, 8'h00);
    access(A_DATA, 1'b0, 8'h00);
    access(A_DATA, 1'b0, 8'h00);

    man_tx_ready = 1'b0;
    push_rx(8'h55);
    for (int i = 0; i < 16; i++) access(A_DATA, 1'b1, 8'(8'h30 + i));
    access(A_CTRL, 1'b0, 8'h00);
    fork
      access(A_DATA, 1'b1, 8'h40);
      begin
        repeat (5) @(posedge clk);
        #1 man_tx_ready = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    access(A_DATA, 1'b0, 8'h00);

    access(A_CTRL, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    check("halted_rdy", int'(rdy_out), 0);
    check("halted_flag", int'(halt_out), 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(32'h0000_0010, 1'b0, 8'h00);

    for (int i = 0; i < 8; i++) access(ram_addr(i), 1'b1, 8'($urandom));
    feed_en    = 1'b1;
    drain_rand = 1'b1;
    repeat (300) begin
      pick = int'($urandom % 10);
      case (pick)
        0, 1:    access(ram_addr(int'($urandom % 8)), 1'b1, 8'($urandom));
        2, 3:    access(ram_addr(int'($urandom % 8)), 1'b0, 8'h00);
        4, 5:    access(A_DATA, 1'b0, 8'h00);
        6, 7:    access(A_DATA, 1'b1, 8'($urandom));
        8:       access(A_CTRL, 1'b0, 8'h00);
        default: access(32'h0003_0000 | 32'(($urandom % 64) * 4 + 8), 1'($urandom % 2), 8'($urandom));
      endcase
    end
    feed_en      = 1'b0;
    drain_rand   = 1'b0;
    man_tx_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
